// File: rtl/invsqrt_req_ctrl_pkg.sv
// Shared FP32 constants, special-value helpers and the requester FSM encoding
// used by the inverse-sqrt request controller.
package invsqrt_req_ctrl_pkg;

  localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF   = 32'h7F80_0000;
  localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;
  localparam logic [31:0] FP32_HALF   = 32'h3F00_0000;
  localparam logic [31:0] FP32_ONEPT5 = 32'h3FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_PUSH  = 2'd3
  } state_t;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
  endfunction

  // Denormals are flushed, so any zero exponent counts as zero.
  function automatic logic is_zero(input logic [31:0] f);
    return f[30:23] == 8'h00;
  endfunction

  function automatic logic is_special(input logic [31:0] f);
    return is_zero(f) || is_nan(f) || is_inf(f) || f[31];
  endfunction

  function automatic logic [31:0] bypass_value(input logic [31:0] f);
    logic [31:0] r;
    if (is_zero(f))                r = FP32_PINF;
    else if (is_nan(f))            r = FP32_QNAN;
    else if (is_inf(f) && !f[31])  r = FP32_ZERO;
    else                           r = FP32_QNAN;
    return r;
  endfunction

endpackage

// File: rtl/invsqrt_req_ctrl_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop may coincide at any
// occupancy, including full, and the head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = pop && !empty;
  assign do_wr   = push && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/invsqrt_req_ctrl.sv
// Requester for the FP32 inverse-sqrt engine: screens IEEE specials locally,
// issues one operand at a time to the engine and returns results in order.
module invsqrt_req_ctrl
  import invsqrt_req_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             eng_start,
  output logic [31:0]      eng_operand,
  input  logic             eng_done,
  input  logic [31:0]      eng_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             err_timeout
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW    = $clog2(DEPTH);

  state_t             state;
  logic               run;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               tmo_hit;
  logic [31:0]        res_data;
  logic [TAG_W-1:0]   res_tag;
  logic               accept;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;

  // run keeps in_ready low while rst_n is asserted and state already reads IDLE.
  assign in_ready  = run && (state == ST_IDLE) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign fifo_push = (state == ST_PUSH);
  assign out_valid = !fifo_empty;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      run         <= 1'b0;
      eng_start   <= 1'b0;
      eng_operand <= '0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      run       <= 1'b1;
      eng_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_special(in_data)) begin
              state <= ST_PUSH;
            end else begin
              eng_operand <= in_data;
              eng_start   <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (eng_done) begin
            state <= ST_PUSH;
          end else if (tmo_hit) begin
            err_timeout <= 1'b1;
            state       <= ST_PUSH;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_PUSH: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result/tag holding registers; a done pulse outside WAIT never reaches them.
  always_ff @(posedge clk) begin
    if (accept) begin
      res_tag  <= in_tag;
      res_data <= bypass_value(in_data);
    end else if (state == ST_WAIT) begin
      if (eng_done)     res_data <= eng_result;
      else if (tmo_hit) res_data <= FP32_QNAN;
    end
  end

  sync_fifo #(
    .WIDTH (32 + TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data ({res_data, res_tag}),
    .pop     (out_ready),
    .rd_data ({out_data, out_tag}),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_invsqrt_req_ctrl.sv
// Bench for invsqrt_req_ctrl with a behavioural inverse-sqrt engine that can
// also act as a never-completing stub.
module tb_invsqrt_req_ctrl;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             eng_start;
  logic [31:0]      eng_operand;
  logic             eng_done = 1'b0;
  logic [31:0]      eng_result = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic             err_timeout;

  always #5 clk = ~clk;

  invsqrt_req_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .eng_start(eng_start),
    .eng_operand(eng_operand), .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_d;
    bit               bypass;
  } vec_t;

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] tag;
    bit               exact;
    logic [31:0]      exp_d;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   eng_lat = 7;
  bit   eng_never = 1'b0;
  bit   rand_lat = 1'b0;
  bit   rand_rdy = 1'b0;
  int   stale_req = 0;
  int   start_cnt = 0;

  function automatic real fp2r(input logic [31:0] f);
    real m;
    real v;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    v = m * (2.0 ** (real'(f[30:23]) - 127.0));
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] b;
    logic [7:0]  e8;
    b  = $realtobits(r);
    e8 = 8'(int'(b[62:52]) - 1023 + 127);
    return {b[63], e8, b[51:29]};
  endfunction

  // Expected result straight from the IEEE screening rules and real arithmetic.
  function automatic void ref_model(input logic [31:0] f, output bit exact, output logic [31:0] r);
    exact = 1'b1;
    if (f[30:23] == 8'h00)                          r = 32'h7F800000;
    else if (f[30:23] == 8'hFF && f[22:0] != 0)     r = 32'h7FC00000;
    else if (f[30:23] == 8'hFF && !f[31])           r = 32'h00000000;
    else if (f[31])                                 r = 32'h7FC00000;
    else begin
      exact = 1'b0;
      r = r2fp(1.0 / $sqrt(fp2r(f)));
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_near(input string name, input logic [31:0] got, input real want);
    real err;
    tests++;
    err = (fp2r(got) - want) / want;
    if (err < 0.0) err = -err;
    if (got[30:23] == 8'hFF || got[30:23] == 8'h00 || err >= 0.002) begin
      fails++;
      $display("FAIL %s: got %h (%f) expected ~%f at %0t", name, got, fp2r(got), want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    out_ready = v;
  endtask

  task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for operand %h", d);
    end else begin
      e.d   = d;
      e.tag = t;
      ref_model(d, e.exact, e.exp_d);
      if (eng_never && !e.exact) begin
        e.exact = 1'b1;
        e.exp_d = 32'h7FC00000;
      end
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk(name, 64'(expq.size()), 64'd0);
  endtask

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    int n;
    int s0;
    logic [31:0] d;

    vecs[0] = '{32'h40800000, 4'd3, 32'h3F000000, 1'b0};
    vecs[1] = '{32'h00000000, 4'd1, 32'h7F800000, 1'b1};
    vecs[2] = '{32'hFF800000, 4'd2, 32'h7FC00000, 1'b1};
    vecs[3] = '{32'h7FC00001, 4'd4, 32'h7FC00000, 1'b1};
    vecs[4] = '{32'h7F800000, 4'd5, 32'h00000000, 1'b1};
    vecs[5] = '{32'h80000000, 4'd6, 32'h7F800000, 1'b1};
    vecs[6] = '{32'h00000001, 4'd7, 32'h7F800000, 1'b1};
    vecs[7] = '{32'hBF800000, 4'd8, 32'h7FC00000, 1'b1};

    fork
      begin : engine
        int          cnt;
        int          seen;
        logic [31:0] op;
        cnt  = 0;
        seen = 0;
        op   = '0;
        forever begin
          @(negedge clk);
          eng_done = 1'b0;
          if (!rst_n) begin
            cnt = 0;
          end else begin
            if (stale_req != seen) begin
              seen       = stale_req;
              eng_done   = 1'b1;
              eng_result = 32'h3F800000;
            end
            if (eng_start) begin
              start_cnt++;
              chk("one_in_flight", 64'(cnt), 64'd0);
              op = eng_operand;
              if (!eng_never) cnt = rand_lat ? int'($urandom_range(1, 12)) : eng_lat;
            end else if (cnt > 0) begin
              chk("operand_hold", 64'(eng_operand), 64'(op));
              cnt--;
              if (cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = r2fp(1.0 / $sqrt(fp2r(op)));
              end
            end
          end
        end
      end
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            expq.delete();
          end else if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_output: got %h tag %0d with nothing pending", out_data, out_tag);
            end else begin
              e = expq.pop_front();
              chk("out_tag", 64'(out_tag), 64'(e.tag));
              if (e.exact) chk("out_data", 64'(out_data), 64'(e.exp_d));
              else         chk_near("out_data", out_data, 1.0 / $sqrt(fp2r(e.d)));
            end
          end
        end
      end
      begin : ready_driver
        forever begin
          @(posedge clk);
          #1;
          if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_eng_operand", 64'(eng_operand), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_timeout", 64'(err_timeout), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors: engine path and bypass latency
    for (int i = 0; i < NV; i++) begin
      s0 = start_cnt;
      send(vecs[i].d, vecs[i].tag);
      if (vecs[i].bypass) begin
        tick();
        chk("bypass_early", 64'(out_valid), 64'd0);
        tick();
        chk("bypass_valid", 64'(out_valid), 64'd1);
        chk("bypass_data", 64'(out_data), 64'(vecs[i].exp_d));
        chk("bypass_tag", 64'(out_tag), 64'(vecs[i].tag));
      end else begin
        n = 0;
        tick();
        while (!eng_done && n < 40) begin
          tick();
          n++;
        end
        chk("eng_done_seen", 64'(eng_done), 64'd1);
        tick();
        chk("eng_early", 64'(out_valid), 64'd0);
        tick();
        chk("eng_valid", 64'(out_valid), 64'd1);
        chk_near("eng_data", out_data, fp2r(vecs[i].exp_d));
        chk("eng_tag", 64'(out_tag), 64'(vecs[i].tag));
      end
      repeat (2) tick();
      chk("start_pulses", 64'(start_cnt - s0), vecs[i].bypass ? 64'd0 : 64'd1);
    end
    chk("no_err_yet", 64'(err_timeout), 64'd0);

    // Engine never completes; a later stale done must be ignored
    eng_never = 1'b1;
    send(32'h40000000, 4'd9);
    n = 0;
    tick();
    n = 1;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk("timeout_latency", 64'(n), 64'(TIMEOUT + 3));
    chk("timeout_data", 64'(out_data), 64'h7FC00000);
    chk("timeout_err", 64'(err_timeout), 64'd1);
    tick();
    stale_req++;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stale_no_output", 64'(out_valid), 64'd0);
    end
    chk("stale_not_busy", 64'(busy), 64'd0);
    chk("err_sticky", 64'(err_timeout), 64'd1);
    eng_never = 1'b0;
    drain("timeout_drain");

    // FIFO fills with out_ready low, then drains in order
    set_ready(1'b0);
    send(32'h3F800000, 4'd1);
    send(32'h40800000, 4'd2);
    send(32'h41800000, 4'd3);
    send(32'h3E800000, 4'd4);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h41100000;
    in_tag   = 4'd5;
    repeat (20) tick();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_head_tag", 64'(out_tag), 64'd1);
    chk_near("full_head_data", out_data, 1.0);
    repeat (3) tick();
    chk("stall_head_tag", 64'(out_tag), 64'd1);
    chk_near("stall_head_data", out_data, 1.0);
    chk("full_still_blocked", 64'(in_ready), 64'd0);
    set_ready(1'b1);
    send(32'h41100000, 4'd5);
    drain("full_drain");

    // Reset while waiting on the engine with two results buffered
    set_ready(1'b0);
    send(32'h00000000, 4'd1);
    send(32'h7F800000, 4'd2);
    send(32'h40800000, 4'd3);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_eng_start", 64'(eng_start), 64'd0);
    chk("midrst_eng_operand", 64'(eng_operand), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_err", 64'(err_timeout), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_empty", 64'(out_valid), 64'd0);
    chk("postrst_busy", 64'(busy), 64'd0);
    tick();
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    set_ready(1'b1);

    // Random mix with random back-pressure and engine latency
    rand_rdy = 1'b1;
    rand_lat = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: d = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
        1: d = {1'($urandom_range(0, 1)), 8'hFF, 23'h0};
        2: d = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom) | 23'h1};
        3: d = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
        default: d = {1'b0, 8'($urandom_range(64, 190)), 23'($urandom)};
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(d, 4'(i));
    end
    drain("random_drain");
    rand_rdy = 1'b0;
    rand_lat = 1'b0;
    set_ready(1'b1);
    chk("random_no_timeout", 64'(err_timeout), 64'd0);
    repeat (3) tick();
    chk("final_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
